// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match sequencer: serve/play/point FSM, scores, winner
// Optional: define PONG_CTRL_SERVE_ALTERNATE_EN to alternate serve direction on every scored point.
module pong_game_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 4,
  parameter int POINT_DELAY = 8,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic               miss_p1,
  input  logic               miss_p2,
  output logic               paddle_en,
  output logic               ball_en,
  output logic               ball_load,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0]         win_q, win_d;
  logic               dir_q, dir_d;
  logic               start_q;
  logic               pe_q, pe_d, be_q, be_d, bl_q, bl_d;
  logic               start_edge;

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          s1_d    = '0;
          s2_d    = '0;
          win_d   = 2'b00;
          dir_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (tick) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        // A simultaneous double miss is treated as a replay: nobody scores.
        if (miss_p1 && miss_p2) begin
          cnt_d   = '0;
          state_d = S_SERVE;
        end else if (miss_p1 || miss_p2) begin
          if (miss_p1) s2_d = s2_q + SCORE_W'(1);
          else         s1_d = s1_q + SCORE_W'(1);
`ifdef PONG_CTRL_SERVE_ALTERNATE_EN
          dir_d = ~dir_q;
`else
          dir_d = miss_p2;
`endif
          cnt_d   = '0;
          state_d = S_POINT;
        end
      end
      S_POINT: begin
        if (tick) begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = '0;
            if (s1_q == WIN_VAL) begin
              win_d   = 2'b01;
              state_d = S_OVER;
            end else if (s2_q == WIN_VAL) begin
              win_d   = 2'b10;
              state_d = S_OVER;
            end else begin
              state_d = S_SERVE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pe_d = (state_d == S_SERVE) || (state_d == S_PLAY) || (state_d == S_POINT);
    be_d = (state_d == S_PLAY);
    bl_d = (state_q == S_SERVE) && (state_d == S_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= 2'b00;
      dir_q   <= 1'b0;
      start_q <= 1'b1;
      pe_q    <= 1'b0;
      be_q    <= 1'b0;
      bl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
      dir_q   <= dir_d;
      start_q <= start;
      pe_q    <= pe_d;
      be_q    <= be_d;
      bl_q    <= bl_d;
    end
  end

  assign paddle_en = pe_q;
  assign ball_en   = be_q;
  assign ball_load = bl_q;
  assign serve_dir = dir_q;
  assign score_p1  = s1_q;
  assign score_p2  = s2_q;
  assign winner    = win_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - vector table plus directed match sequences for pong_game_ctrl
module tb_pong_game_ctrl;

  localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b1, miss_p1 = 1'b0, miss_p2 = 1'b0;
  logic       paddle_en, ball_en, ball_load, serve_dir;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  pong_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .miss_p1(miss_p1), .miss_p2(miss_p2),
    .paddle_en(paddle_en), .ball_en(ball_en), .ball_load(ball_load),
    .serve_dir(serve_dir), .score_p1(score_p1), .score_p2(score_p2),
    .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, tk, m1, m2;
    logic [2:0] e_state;
    logic       e_pe, e_be, e_bl, e_dir;
    logic [3:0] e_s1, e_s2;
    logic [1:0] e_win;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic st, logic tk, logic m1, logic m2, logic [2:0] es,
                              logic pe, logic be, logic bl, logic dir,
                              logic [3:0] s1, logic [3:0] s2, logic [1:0] w);
    vec_t v;
    v.st = st; v.tk = tk; v.m1 = m1; v.m2 = m2; v.e_state = es;
    v.e_pe = pe; v.e_be = be; v.e_bl = bl; v.e_dir = dir;
    v.e_s1 = s1; v.e_s2 = s2; v.e_win = w;
    return v;
  endfunction

  task automatic step(input logic st, input logic tk, input logic m1, input logic m2);
    @(negedge clk);
    start = st; tick = tk; miss_p1 = m1; miss_p2 = m2;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [2:0] es, input logic pe, input logic be,
                     input logic bl, input logic dir, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [1:0] w);
    logic [18:0] got, exp;
    got = {state, paddle_en, ball_en, ball_load, serve_dir, score_p1, score_p2, winner};
    exp = {es, pe, be, bl, dir, s1, s2, w};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got state=%0d pe=%b be=%b bl=%b dir=%b s1=%0d s2=%0d win=%b, need state=%0d pe=%b be=%b bl=%b dir=%b s1=%0d s2=%0d win=%b",
               nm, state, paddle_en, ball_en, ball_load, serve_dir, score_p1, score_p2, winner,
               es, pe, be, bl, dir, s1, s2, w);
    end
  endtask

  initial begin
    logic       dir_m;
    logic [3:0] s1_m, s2_m;

    // start held high through reset must not count as a press
    vt.push_back(mk(1,0,0,0, IDLE, 0,0,0,0, 0,0,2'b00));
    vt.push_back(mk(1,0,0,0, IDLE, 0,0,0,0, 0,0,2'b00));
    vt.push_back(mk(0,1,0,0, IDLE, 0,0,0,0, 0,0,2'b00));
    vt.push_back(mk(1,1,0,0, SERVE,1,0,0,0, 0,0,2'b00));
    vt.push_back(mk(1,0,0,0, SERVE,1,0,0,0, 0,0,2'b00));
    vt.push_back(mk(1,1,0,0, SERVE,1,0,0,0, 0,0,2'b00));
    vt.push_back(mk(1,1,0,0, SERVE,1,0,0,0, 0,0,2'b00));
    vt.push_back(mk(0,1,1,0, SERVE,1,0,0,0, 0,0,2'b00));
    vt.push_back(mk(0,1,0,0, PLAY, 1,1,1,0, 0,0,2'b00));
    vt.push_back(mk(0,0,0,0, PLAY, 1,1,0,0, 0,0,2'b00));
    vt.push_back(mk(1,1,0,0, PLAY, 1,1,0,0, 0,0,2'b00));
    vt.push_back(mk(1,0,0,1, POINT,1,0,0,1, 1,0,2'b00));
    vt.push_back(mk(1,0,1,1, POINT,1,0,0,1, 1,0,2'b00));
    for (int i = 0; i < 7; i++) vt.push_back(mk(0,1,0,0, POINT,1,0,0,1, 1,0,2'b00));
    vt.push_back(mk(0,1,0,0, SERVE,1,0,0,1, 1,0,2'b00));
    for (int i = 0; i < 3; i++) vt.push_back(mk(0,1,0,0, SERVE,1,0,0,1, 1,0,2'b00));
    vt.push_back(mk(0,1,0,0, PLAY, 1,1,1,1, 1,0,2'b00));
    vt.push_back(mk(0,0,1,1, SERVE,1,0,0,1, 1,0,2'b00));
    for (int i = 0; i < 3; i++) vt.push_back(mk(0,1,0,0, SERVE,1,0,0,1, 1,0,2'b00));
    vt.push_back(mk(0,1,0,0, PLAY, 1,1,1,1, 1,0,2'b00));

    rst_n = 1'b0;
    #12;
    chk("reset", IDLE, 0,0,0,0, 0,0,2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].st, vt[i].tk, vt[i].m1, vt[i].m2);
      chk($sformatf("vec%0d", i), vt[i].e_state, vt[i].e_pe, vt[i].e_be, vt[i].e_bl,
          vt[i].e_dir, vt[i].e_s1, vt[i].e_s2, vt[i].e_win);
    end

    // Player 1 runs the score up to the winning value
    dir_m = 1'b1;
    s1_m  = 4'd1;
    while (s1_m < 4'd9) begin
      s1_m++;
`ifdef PONG_CTRL_SERVE_ALTERNATE_EN
      dir_m = ~dir_m;
`else
      dir_m = 1'b1;
`endif
      step(0,0,0,1);
      chk("p1_point", POINT, 1,0,0,dir_m, s1_m,0,2'b00);
      for (int t = 0; t < 7; t++) step(0,1,0,0);
      chk("p1_point_hold", POINT, 1,0,0,dir_m, s1_m,0,2'b00);
      step(0,1,0,0);
      if (s1_m == 4'd9) begin
        chk("p1_over", OVER, 0,0,0,dir_m, 4'd9,0,2'b01);
      end else begin
        chk("p1_serve", SERVE, 1,0,0,dir_m, s1_m,0,2'b00);
        for (int t = 0; t < 4; t++) step(0,1,0,0);
        chk("p1_play", PLAY, 1,1,1,dir_m, s1_m,0,2'b00);
      end
    end
    step(0,1,1,0);
    chk("over_hold", OVER, 0,0,0,dir_m, 4'd9,0,2'b01);
    step(1,0,0,0);
    chk("restart", SERVE, 1,0,0,0, 0,0,2'b00);

    // Player 2 reaches five, then reset lands mid-rally
    dir_m = 1'b0;
    s2_m  = 4'd0;
    for (int p = 0; p < 5; p++) begin
      for (int t = 0; t < 4; t++) step(0,1,0,0);
      step(0,0,1,0);
      s2_m++;
`ifdef PONG_CTRL_SERVE_ALTERNATE_EN
      dir_m = ~dir_m;
`else
      dir_m = 1'b0;
`endif
      chk("p2_point", POINT, 1,0,0,dir_m, 0,s2_m,2'b00);
      for (int t = 0; t < 8; t++) step(0,1,0,0);
    end
    chk("p2_serve", SERVE, 1,0,0,dir_m, 0,4'd5,2'b00);
    for (int t = 0; t < 4; t++) step(0,1,0,0);
    step(1,0,0,0);
    chk("start_in_play", PLAY, 1,1,0,dir_m, 0,4'd5,2'b00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", IDLE, 0,0,0,0, 0,0,2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1,1,0,0);
    chk("post_reset_held", IDLE, 0,0,0,0, 0,0,2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
